// File: rtl/count_seq_monitor.sv
// Consumer-side checker for a free-running up-counter bus: predicts prev+1 on every
// enabled sample, locks after a run of good steps, then reports errors, wraps and restarts.
module count_seq_monitor #(
    parameter int WIDTH         = 4,
    parameter int LOCK_COUNT    = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         q_in,
    output logic                     locked,
    output logic                     err_pulse,
    output logic                     restart_pulse,
    output logic                     wrap_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_COUNT);

    state_t                   r_state, w_state_nxt;
    logic [WIDTH-1:0]         r_prev, w_prev_nxt, w_exp;
    logic [3:0]               r_run, w_run_nxt;
    logic [4:0]               w_run_inc;
    logic                     r_locked, r_err, r_restart, r_wrap;
    logic                     w_err_nxt, w_restart_nxt, w_wrap_nxt;
    logic [ERR_CNT_WIDTH-1:0] r_err_count, w_err_count_nxt;

    assign w_exp     = r_prev + WIDTH'(1);
    assign w_run_inc = {1'b0, r_run} + 5'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_run_nxt       = r_run;
        w_err_nxt       = 1'b0;
        w_restart_nxt   = 1'b0;
        w_wrap_nxt      = 1'b0;
        w_err_count_nxt = r_err_count;
        if (en) begin
            w_prev_nxt = q_in;
            case (r_state)
                S_IDLE: begin
                    w_run_nxt   = 4'd0;
                    w_state_nxt = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (q_in == w_exp) begin
                        w_run_nxt = w_run_inc[3:0];
                        if (w_run_inc == LOCK_TGT) w_state_nxt = S_LOCKED;
                    end else begin
                        w_run_nxt = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (q_in == w_exp) begin
                        w_wrap_nxt = (r_prev == MAX_VAL);
                    end else if (q_in == '0) begin
                        // Upstream counter reset: legal, stay locked on the new origin
                        w_restart_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_run_nxt   = 4'd0;
                        w_state_nxt = S_ACQUIRE;
                        if (r_err_count != '1) w_err_count_nxt = r_err_count + ERR_CNT_WIDTH'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_run       <= 4'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_restart   <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_run       <= w_run_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
            r_err       <= w_err_nxt;
            r_restart   <= w_restart_nxt;
            r_wrap      <= w_wrap_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked        = r_locked;
    assign err_pulse     = r_err;
    assign restart_pulse = r_restart;
    assign wrap_pulse    = r_wrap;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed vector table, a re-lock sequence, and random
// stimulus against a behavioural model. Two instances share inputs (8-bit and 2-bit error counters).
module tb_count_seq_monitor;

    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] q_in = 4'd0;

    logic       a_locked, a_err, a_restart, a_wrap;
    logic [7:0] a_err_count;
    logic       b_locked, b_err, b_restart, b_wrap;
    logic [1:0] b_err_count;

    count_seq_monitor #(.WIDTH(4), .LOCK_COUNT(LOCK), .ERR_CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in),
        .locked(a_locked), .err_pulse(a_err), .restart_pulse(a_restart),
        .wrap_pulse(a_wrap), .err_count(a_err_count)
    );

    count_seq_monitor #(.WIDTH(4), .LOCK_COUNT(LOCK), .ERR_CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in),
        .locked(b_locked), .err_pulse(b_err), .restart_pulse(b_restart),
        .wrap_pulse(b_wrap), .err_count(b_err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural reference state
    int m_st = 0;  // 0 idle, 1 acquiring, 2 locked
    int m_prev = 0, m_run = 0, m_ca = 0, m_cb = 0;
    bit m_err = 0, m_rs = 0, m_wr = 0;

    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] q;
        bit         l;
        bit         e;
        bit         rs;
        bit         w;
        int         ca;
        int         cb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int q);
        int exp_v;
        m_err = 0; m_rs = 0; m_wr = 0;
        if (r) begin
            m_st = 0; m_prev = 0; m_run = 0; m_ca = 0; m_cb = 0;
        end else if (e) begin
            exp_v = (m_prev + 1) % 16;
            if (m_st == 0) begin
                m_st = 1; m_run = 0;
            end else if (m_st == 1) begin
                if (q == exp_v) begin
                    m_run++;
                    if (m_run == LOCK) m_st = 2;
                end else m_run = 0;
            end else begin
                if (q == exp_v) m_wr = (m_prev == 15);
                else if (q == 0) m_rs = 1;
                else begin
                    m_err = 1;
                    m_ca = (m_ca < 255) ? m_ca + 1 : 255;
                    m_cb = (m_cb < 3) ? m_cb + 1 : 3;
                    m_st = 1; m_run = 0;
                end
            end
            m_prev = q;
        end
    endtask

    task automatic apply(input bit r, input bit e, input int q);
        reset = r; en = e; q_in = 4'(q);
        @(posedge clk);
        #1;
        model_step(r, e, q);
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d_a_locked", cyc), {31'b0, a_locked}, (m_st == 2) ? 1 : 0);
        chk($sformatf("rnd%0d_a_err", cyc), {31'b0, a_err}, {31'b0, m_err});
        chk($sformatf("rnd%0d_a_restart", cyc), {31'b0, a_restart}, {31'b0, m_rs});
        chk($sformatf("rnd%0d_a_wrap", cyc), {31'b0, a_wrap}, {31'b0, m_wr});
        chk($sformatf("rnd%0d_a_errcnt", cyc), {24'b0, a_err_count}, m_ca);
        chk($sformatf("rnd%0d_b_locked", cyc), {31'b0, b_locked}, (m_st == 2) ? 1 : 0);
        chk($sformatf("rnd%0d_b_errcnt", cyc), {30'b0, b_err_count}, m_cb);
    endtask

    function automatic vec_t v(bit r, bit e, int q, bit l, bit er, bit rs, bit w, int ca, int cb);
        vec_t t;
        t.rst = r; t.en = e; t.q = 4'(q); t.l = l; t.e = er; t.rs = rs; t.w = w; t.ca = ca; t.cb = cb;
        return t;
    endfunction

    initial begin
        int cnt;
        // Directed table: clean count, restart, jump, wrap, stuck, en hold, saturation, reset
        vecs.push_back(v(1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 5,  0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 1,  0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 2,  1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 3,  1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0,  1, 0, 1, 0, 0, 0));
        for (int k = 1; k <= 5; k++) vecs.push_back(v(0, 1, k, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 9,  0, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 10, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 11, 1, 0, 0, 0, 1, 1));
        for (int k = 12; k <= 15; k++) vecs.push_back(v(0, 1, k, 1, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 0,  1, 0, 0, 1, 1, 1));
        for (int k = 1; k <= 7; k++) vecs.push_back(v(0, 1, k, 1, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 7,  0, 1, 0, 0, 2, 2));
        vecs.push_back(v(0, 1, 7,  0, 0, 0, 0, 2, 2));
        vecs.push_back(v(0, 1, 8,  0, 0, 0, 0, 2, 2));
        vecs.push_back(v(0, 1, 9,  1, 0, 0, 0, 2, 2));
        vecs.push_back(v(0, 0, 10, 1, 0, 0, 0, 2, 2));
        vecs.push_back(v(0, 0, 11, 1, 0, 0, 0, 2, 2));
        vecs.push_back(v(0, 0, 12, 1, 0, 0, 0, 2, 2));
        vecs.push_back(v(0, 1, 13, 0, 1, 0, 0, 3, 3));
        vecs.push_back(v(0, 1, 14, 0, 0, 0, 0, 3, 3));
        vecs.push_back(v(0, 1, 15, 1, 0, 0, 0, 3, 3));
        vecs.push_back(v(0, 1, 0,  1, 0, 0, 1, 3, 3));
        vecs.push_back(v(0, 1, 5,  0, 1, 0, 0, 4, 3));
        vecs.push_back(v(0, 1, 9,  0, 0, 0, 0, 4, 3));
        vecs.push_back(v(1, 1, 3,  0, 0, 0, 0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].en, int'(vecs[i].q));
            chk($sformatf("vec%0d_locked", i), {31'b0, a_locked}, {31'b0, vecs[i].l});
            chk($sformatf("vec%0d_err", i), {31'b0, a_err}, {31'b0, vecs[i].e});
            chk($sformatf("vec%0d_restart", i), {31'b0, a_restart}, {31'b0, vecs[i].rs});
            chk($sformatf("vec%0d_wrap", i), {31'b0, a_wrap}, {31'b0, vecs[i].w});
            chk($sformatf("vec%0d_errcnt_a", i), {24'b0, a_err_count}, vecs[i].ca);
            chk($sformatf("vec%0d_errcnt_b", i), {30'b0, b_err_count}, vecs[i].cb);
            chk($sformatf("vec%0d_locked_b", i), {31'b0, b_locked}, {31'b0, vecs[i].l});
        end

        // Reset mid-lock, then re-lock needs 1 + LOCK enabled samples
        apply(0, 1, 4); apply(0, 1, 5); apply(0, 1, 6);
        chk("relock_pre", {31'b0, a_locked}, 1);
        apply(1, 1, 7);
        chk("relock_rst_locked", {31'b0, a_locked}, 0);
        chk("relock_rst_err", {31'b0, a_err}, 0);
        apply(0, 1, 8);
        chk("relock_s1", {31'b0, a_locked}, 0);
        apply(0, 1, 9);
        chk("relock_s2", {31'b0, a_locked}, 0);
        apply(0, 1, 10);
        chk("relock_s3", {31'b0, a_locked}, 1);
        chk("relock_wrap", {31'b0, a_wrap}, 0);

        // Random stimulus: mostly counting, with restarts, holds, jumps, stalls and resets
        cnt = 10;
        for (int c = 0; c < 3000; c++) begin
            int k;
            bit r, e;
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) != 0);
            k = $urandom_range(0, 99);
            if (k < 80)      cnt = (cnt + 1) % 16;
            else if (k < 86) cnt = 0;
            else if (k < 92) cnt = cnt;
            else             cnt = $urandom_range(0, 15);
            apply(r, e, cnt);
            check_model(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
